// File: rtl/vga_pattern.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pattern
//  Purpose  : Test-pattern pixel stage that sits after the VGA timing
//             generator. It registers the incoming position and syncs, then
//             drives 3-3-2 RGB and re-timed syncs to the board pins. There
//             are four patterns: colour bars, checker, gradient, and a
//             bouncing box. Pipeline latency is 2 clocks.
//  Options  : VGA_PATTERN_BORDER_EN - overlay a 1-pixel white border on the
//             edge of the visible area (this overrides every pattern).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_pattern #(
  parameter int H_ACTIVE = 1600,
  parameter int V_ACTIVE = 1200,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [12:0] H_IN,
  input  logic [12:0] V_IN,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  input  logic        ACTIVE_IN,
  input  logic [1:0]  MODE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [2:0]  RED,
  output logic [2:0]  GREEN,
  output logic [1:0]  BLUE,
  output logic        FRAME
);

  localparam logic [12:0] c_xmax   = 13'(H_ACTIVE - BOX_SIZE);
  localparam logic [12:0] c_ymax   = 13'(V_ACTIVE - BOX_SIZE);
  localparam logic [12:0] c_step   = 13'(BOX_STEP);
  localparam logic [13:0] c_size   = 14'(BOX_SIZE);
  localparam logic [12:0] c_v_evt  = 13'(V_ACTIVE);
  localparam logic [7:0]  c_white  = 8'hFF;
  localparam logic [7:0]  c_box_bg = 8'h01;

  // Frame-level state, updated only on the frame-start event
  logic [1:0]  r_mode;
  logic [7:0]  r_frame_cnt;
  logic [12:0] r_box_x;
  logic [12:0] r_box_y;
  logic        r_x_neg;      // 1 = box moving toward smaller x
  logic        r_y_neg;
  logic        r_frame;

  // Stage 1 registers
  logic [12:0] r_h1;
  logic [2:0]  r_v1_hi;      // V[7:5], the only vertical bits the patterns use
  logic        r_act1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_hit1;

  // Stage 2 (output) registers
  logic        r_hs2;
  logic        r_vs2;
  logic [7:0]  r_rgb2;

  logic        w_frame_evt;
  logic        w_hit;
  logic [13:0] w_x_nxt;      // {new direction, new position}
  logic [13:0] w_y_nxt;
  logic [2:0]  w_bar_k;
  logic [7:0]  w_rgb;

  // Each axis bounces between 0 and lim, clamping so it never overshoots
  function automatic logic [13:0] f_bounce(input logic [12:0] pos,
                                           input logic        neg,
                                           input logic [12:0] lim);
    logic [13:0] res;
    if (!neg) begin
      if (pos + c_step >= lim) res = {1'b1, lim};
      else                     res = {1'b0, pos + c_step};
    end else begin
      if (pos <= c_step) res = {1'b0, 13'd0};
      else               res = {1'b1, pos - c_step};
    end
    return res;
  endfunction

  // The first blanking line, column 0, marks the frame boundary
  assign w_frame_evt = (H_IN == 13'd0) && (V_IN == c_v_evt);
  assign w_x_nxt     = f_bounce(r_box_x, r_x_neg, c_xmax);
  assign w_y_nxt     = f_bounce(r_box_y, r_y_neg, c_ymax);

  // The box hit test uses only registered box state, so it cannot tear mid-frame
  assign w_hit = ({1'b0, H_IN} >= {1'b0, r_box_x}) &&
                 ({1'b0, H_IN} <  ({1'b0, r_box_x} + c_size)) &&
                 ({1'b0, V_IN} >= {1'b0, r_box_y}) &&
                 ({1'b0, V_IN} <  ({1'b0, r_box_y} + c_size));

  // Per-frame state: latch mode, advance counter and box, pulse FRAME
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode      <= 2'd0;
      r_frame_cnt <= 8'd0;
      r_box_x     <= 13'd0;
      r_box_y     <= 13'd0;
      r_x_neg     <= 1'b0;
      r_y_neg     <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_frame <= w_frame_evt;
      if (w_frame_evt) begin
        r_mode      <= MODE;
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_box_x     <= w_x_nxt[12:0];
        r_x_neg     <= w_x_nxt[13];
        r_box_y     <= w_y_nxt[12:0];
        r_y_neg     <= w_y_nxt[13];
      end
    end
  end

`ifdef VGA_PATTERN_BORDER_EN
  logic r_edge1;

  // Border flag travels with stage 1 so latency is unchanged
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_edge1 <= 1'b0;
    end else begin
      r_edge1 <= (H_IN == 13'd0) || (H_IN == 13'(H_ACTIVE - 1)) ||
                 (V_IN == 13'd0) || (V_IN == 13'(V_ACTIVE - 1));
    end
  end
`endif

  // Stage 1: capture position, syncs, active flag and box hit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_h1    <= 13'd0;
      r_v1_hi <= 3'd0;
      r_act1  <= 1'b0;
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_hit1  <= 1'b0;
    end else begin
      r_h1    <= H_IN;
      r_v1_hi <= V_IN[7:5];
      r_act1  <= ACTIVE_IN;
      r_hs1   <= HSYNC_IN;
      r_vs1   <= VSYNC_IN;
      r_hit1  <= w_hit;
    end
  end

  // Colour mux: bar index comes from constant thresholds, not a divider
  always_comb begin
    w_bar_k = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_h1 >= 13'(i * (H_ACTIVE / 8))) w_bar_k = 3'(i);
    end

    w_rgb = 8'h00;
    case (r_mode)
      2'd0:    w_rgb = {{3{w_bar_k[2]}}, {3{w_bar_k[1]}}, {2{w_bar_k[0]}}};
      2'd1:    w_rgb = (r_h1[5] ^ r_v1_hi[0]) ? c_white : 8'h00;
      2'd2:    w_rgb = {r_h1[7:5], r_v1_hi, r_frame_cnt[7:6]};
      default: w_rgb = r_hit1 ? c_white : c_box_bg;
    endcase

`ifdef VGA_PATTERN_BORDER_EN
    if (r_edge1) w_rgb = c_white;
`endif

    if (!r_act1) w_rgb = 8'h00;
  end

  // Stage 2: register the pixel together with the second sync delay
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_rgb2 <= 8'h00;
    end else begin
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_rgb2 <= w_rgb;
    end
  end

  assign HSYNC = r_hs2;
  assign VSYNC = r_vs2;
  assign RED   = r_rgb2[7:5];
  assign GREEN = r_rgb2[4:2];
  assign BLUE  = r_rgb2[1:0];
  assign FRAME = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pattern
//  Purpose  : Directed self-checking bench for vga_pattern. The bench drives
//             position and sync inputs directly, so a frame boundary costs
//             only two clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pattern;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [12:0] H_IN;
  logic [12:0] V_IN;
  logic        HSYNC_IN;
  logic        VSYNC_IN;
  logic        ACTIVE_IN;
  logic [1:0]  MODE;
  logic        HSYNC;
  logic        VSYNC;
  logic [2:0]  RED;
  logic [2:0]  GREEN;
  logic [1:0]  BLUE;
  logic        FRAME;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [7:0] c_bars_h0   = 8'hFF;
  localparam logic [7:0] c_box_h0    = 8'hFF;
`else
  localparam logic [7:0] c_bars_h0   = 8'h00;
  localparam logic [7:0] c_box_h0    = 8'h01;
`endif

  vga_pattern dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .H_IN      (H_IN),
    .V_IN      (V_IN),
    .HSYNC_IN  (HSYNC_IN),
    .VSYNC_IN  (VSYNC_IN),
    .ACTIVE_IN (ACTIVE_IN),
    .MODE      (MODE),
    .HSYNC     (HSYNC),
    .VSYNC     (VSYNC),
    .RED       (RED),
    .GREEN     (GREEN),
    .BLUE      (BLUE),
    .FRAME     (FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Present one active pixel and check the colour two clocks later
  task automatic pix(input logic [12:0] h, input logic [12:0] v, input logic act,
                     input logic [7:0] exp, input string tag);
    H_IN      = h;
    V_IN      = v;
    ACTIVE_IN = act;
    repeat (2) @(posedge CLK);
    #1;
    chk(tag, {RED, GREEN, BLUE}, exp);
  endtask

  // One frame-start event followed by one idle blanking cycle
  task automatic frame_evt();
    H_IN      = 13'd0;
    V_IN      = 13'd1200;
    ACTIVE_IN = 1'b0;
    @(posedge CLK);
    #1;
    chk("frame_hi", FRAME, 1);
    V_IN = 13'd1201;
    @(posedge CLK);
    #1;
    chk("frame_lo", FRAME, 0);
  endtask

  task automatic events(input int n);
    for (int i = 0; i < n; i++) frame_evt();
  endtask

  initial begin
    // Reset held with syncs low and an event pattern on the inputs
    RST_N     = 1'b0;
    H_IN      = 13'd0;
    V_IN      = 13'd1200;
    HSYNC_IN  = 1'b0;
    VSYNC_IN  = 1'b0;
    ACTIVE_IN = 1'b1;
    MODE      = 2'd1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hsync", HSYNC, 1);
    chk("rst_vsync", VSYNC, 1);
    chk("rst_rgb",   {RED, GREEN, BLUE}, 8'h00);
    chk("rst_frame", FRAME, 0);

    RST_N    = 1'b1;
    V_IN     = 13'd0;
    HSYNC_IN = 1'b1;
    VSYNC_IN = 1'b1;
    MODE     = 2'd0;
    pix(13'd0, 13'd0, 1'b1, c_bars_h0, "bars_h0");
    chk("no_x", 32'($isunknown({HSYNC, VSYNC, RED, GREEN, BLUE, FRAME})), 0);

    // Latency: sync and pixel appear together two clocks after input
    H_IN     = 13'd200;
    V_IN     = 13'd100;
    HSYNC_IN = 1'b0;
    VSYNC_IN = 1'b0;
    @(posedge CLK);
    #1;
    chk("lat_hs_n1", HSYNC, 1);
    @(posedge CLK);
    #1;
    chk("lat_hs_n2", HSYNC, 0);
    chk("lat_vs_n2", VSYNC, 0);
    chk("lat_rgb",   {RED, GREEN, BLUE}, 8'h03);
    HSYNC_IN = 1'b1;
    VSYNC_IN = 1'b1;
    @(posedge CLK);
    #1;
    chk("lat_hs_hold", HSYNC, 0);
    @(posedge CLK);
    #1;
    chk("lat_hs_rise", HSYNC, 1);

    // Colour bars
    pix(13'd1599, 13'd100, 1'b1, 8'hFF, "bars_h1599");
    pix(13'd799,  13'd100, 1'b1, 8'h1F, "bars_h799");
    pix(13'd800,  13'd100, 1'b1, 8'hE0, "bars_h800");
    pix(13'd1000, 13'd100, 1'b0, 8'h00, "bars_inactive");

    // Mode change mid-frame is held off until the frame boundary
    MODE = 2'd1;
    pix(13'd200, 13'd600, 1'b1, 8'h03, "mode_hold");
    frame_evt();
    pix(13'd32, 13'd0,  1'b1, 8'hFF, "chk_32_0");
    pix(13'd32, 13'd32, 1'b1, 8'h00, "chk_32_32");
    pix(13'd64, 13'd32, 1'b1, 8'hFF, "chk_64_32");

    // Gradient with frame_cnt = 2
    MODE = 2'd2;
    frame_evt();
    pix(13'd160, 13'd96, 1'b1, 8'hAC, "grad_fc2");

    // Asynchronous reset mid-frame
    HSYNC_IN = 1'b0;
    pix(13'd500, 13'd500, 1'b1, 8'hFC, "grad_pre_rst");
    chk("pre_rst_hsync", HSYNC, 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_hsync", HSYNC, 1);
    chk("midrst_rgb",   {RED, GREEN, BLUE}, 8'h00);
    @(posedge CLK);
    #1;
    RST_N    = 1'b1;
    HSYNC_IN = 1'b1;
    MODE     = 2'd3;
    pix(13'd200, 13'd500, 1'b1, 8'h03, "mode_cleared");

    // Bouncing box: first event moves it from (0,0) to (4,4)
    frame_evt();
    pix(13'd4,  13'd4,  1'b1, 8'hFF, "box1_in");
    pix(13'd3,  13'd4,  1'b1, 8'h01, "box1_left");
    pix(13'd4,  13'd3,  1'b1, 8'h01, "box1_top");
    pix(13'd67, 13'd67, 1'b1, 8'hFF, "box1_corner");
    pix(13'd68, 13'd67, 1'b1, 8'h01, "box1_right");

    // 284 frames: y clamps at 1136 and reverses, x at 1136 moving +
    events(283);
    pix(13'd1136, 13'd1136, 1'b1, 8'hFF, "box284_in");
    pix(13'd1136, 13'd1135, 1'b1, 8'h01, "box284_top");
    pix(13'd1136, 13'd1198, 1'b1, 8'hFF, "box284_bot");
    pix(13'd1200, 13'd1136, 1'b1, 8'h01, "box284_right");

    events(1);
    pix(13'd1140, 13'd1132, 1'b1, 8'hFF, "box285_in");
    pix(13'd1140, 13'd1131, 1'b1, 8'h01, "box285_top");
    pix(13'd1139, 13'd1132, 1'b1, 8'h01, "box285_left");

    // 384 frames: x clamps at 1536, y back down to 736
    events(99);
    pix(13'd1536, 13'd736, 1'b1, 8'hFF, "box384_in");
    pix(13'd1535, 13'd736, 1'b1, 8'h01, "box384_left");
    pix(13'd1598, 13'd799, 1'b1, 8'hFF, "box384_corner");
    pix(13'd1598, 13'd800, 1'b1, 8'h01, "box384_below");

    // 385 frames: x reverses to 1532, y 732
    events(1);
    pix(13'd1532, 13'd732, 1'b1, 8'hFF, "box385_in");
    pix(13'd1596, 13'd732, 1'b1, 8'h01, "box385_right");
    pix(13'd1595, 13'd795, 1'b1, 8'hFF, "box385_corner");
    pix(13'd1595, 13'd796, 1'b1, 8'h01, "box385_below");
    pix(13'd0,    13'd500, 1'b1, c_box_h0, "border_h0");

    // Gradient again: frame_cnt = 386 mod 256 = 130, so B = 2
    MODE = 2'd2;
    frame_evt();
    pix(13'd160, 13'd96, 1'b1, 8'hAE, "grad_fc130");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
